// File: rtl/multicycle_ctrl.sv
//==============================================================================
// multicycle_ctrl
//   Multicycle control FSM for a LEGv8-subset datapath. Optional build macro
//   CTRL_PERF_CNT_EN adds a retired-instruction counter output.
//   Revision: 1.0
//==============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        pc_src,
  output logic        reg2_loc,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [1:0]  err_code
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam logic [15:0] WAIT_LIMIT = 16'(MEM_WAIT_MAX);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_CBZ    = 4'd8,
    S_BR     = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [10:0] ir_op;
  logic [15:0] wait_cnt;
  logic [1:0]  err_reg;
  logic        mem_state;
  logic        timeout;
  logic        is_rtype;
  logic        is_ldur;
  logic        is_stur;
  logic        is_cbz;
  logic        is_b;
  logic [3:0]  r_alu_op;
  logic        unused_instr;

  // Only the opcode field is kept; operand fields go straight to the datapath.
  assign unused_instr = ^instr[20:0];

  assign is_ldur  = (ir_op == OPC_LDUR);
  assign is_stur  = (ir_op == OPC_STUR);
  assign is_cbz   = (ir_op[10:3] == 8'b10110100);
  assign is_b     = (ir_op[10:5] == 6'b000101);
  assign is_rtype = (ir_op == OPC_ADD) || (ir_op == OPC_SUB) ||
                    (ir_op == OPC_AND) || (ir_op == OPC_ORR);

  always_comb begin
    r_alu_op = ALU_ADD;
    case (ir_op)
      OPC_SUB: r_alu_op = ALU_SUB;
      OPC_AND: r_alu_op = ALU_AND;
      OPC_ORR: r_alu_op = ALU_OR;
      default: r_alu_op = ALU_ADD;
    endcase
  end

  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err_reg  <= 2'b00;
      ir_op    <= '0;
`ifdef CTRL_PERF_CNT_EN
      retired  <= '0;
`endif
    end else begin
      state <= state_nx;
      // Counts consecutive not-ready cycles within one memory state; any exit clears it.
      if (mem_state && !mem_ready && (state_nx == state))
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
      if ((state == S_FETCH) && mem_ready)
        ir_op <= instr[31:21];
      if ((state_nx == S_TRAP) && (state != S_TRAP))
        err_reg <= timeout ? 2'b10 : 2'b01;
`ifdef CTRL_PERF_CNT_EN
      if ((state_nx == S_FETCH) &&
          ((state == S_WB_R) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
           (state == S_CBZ) || (state == S_BR)))
        retired <= retired + 32'd1;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    alu_op     = 4'b0000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 1'b0;
    reg2_loc   = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    err_code   = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read  = !timeout;
        alu_op    = ALU_ADD;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end else if (timeout) begin
          state_nx = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_rtype)                state_nx = S_EXEC_R;
        else if (is_ldur || is_stur) state_nx = S_ADDR;
        else if (is_cbz)             state_nx = S_CBZ;
        else if (is_b)               state_nx = S_BR;
        else                         state_nx = S_TRAP;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        state_nx  = S_WB_R;
      end
      S_WB_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_nx  = is_ldur ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        mem_read  = !timeout;
        if (mem_ready)    state_nx = S_WB_MEM;
        else if (timeout) state_nx = S_TRAP;
      end
      S_MEM_WR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        reg2_loc  = 1'b1;
        mem_write = !timeout;
        if (mem_ready)    state_nx = S_FETCH;
        else if (timeout) state_nx = S_TRAP;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nx   = S_FETCH;
      end
      S_CBZ: begin
        reg2_loc = 1'b1;
        alu_op   = ALU_PASS;
        pc_write = zero;
        pc_src   = zero;
        state_nx = S_FETCH;
      end
      S_BR: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
        state_nx = S_FETCH;
      end
      S_TRAP: begin
        illegal  = 1'b1;
        err_code = err_reg;
      end
      default: state_nx = S_FETCH;
    endcase
    // Outputs are forced quiet for the whole reset cycle so an aborted
    // instruction never leaks a partial write.
    if (rst) begin
      alu_op     = 4'b0000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      pc_src     = 1'b0;
      reg2_loc   = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      err_code   = 2'b00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//==============================================================================
// tb_multicycle_ctrl
//   Randomized self-checking bench: per-cycle expected outputs are planned
//   from instruction class, wait counts and the zero flag.
//   Revision: 1.0
//==============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int MAXW = 4;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;

  localparam logic [8:0] MR  = 9'h100;
  localparam logic [8:0] MW  = 9'h080;
  localparam logic [8:0] IRW = 9'h040;
  localparam logic [8:0] PCW = 9'h020;
  localparam logic [8:0] RW  = 9'h010;
  localparam logic [8:0] PCS = 9'h008;
  localparam logic [8:0] R2L = 9'h004;
  localparam logic [8:0] M2R = 9'h002;
  localparam logic [8:0] ILL = 9'h001;

  localparam logic [10:0] C_ADD  = 11'b10001011000;
  localparam logic [10:0] C_SUB  = 11'b11001011000;
  localparam logic [10:0] C_AND  = 11'b10001010000;
  localparam logic [10:0] C_ORR  = 11'b10101010000;
  localparam logic [10:0] C_LDUR = 11'b11111000010;
  localparam logic [10:0] C_STUR = 11'b11111000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [3:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        mem_read, mem_write, ir_write, pc_write, reg_write;
  logic        pc_src, reg2_loc, mem_to_reg, illegal;
  logic [1:0]  err_code;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned retired_model = 0;

  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [31:0] ins;
    logic [17:0] e;
  } step_t;
  step_t plan[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src),
    .reg2_loc(reg2_loc), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .err_code(err_code)
`ifdef CTRL_PERF_CNT_EN
    , .retired(retired)
`endif
  );

  function automatic logic [17:0] ev(logic [3:0] op, logic sa, logic [1:0] sb,
                                     logic [8:0] s, logic [1:0] ec);
    return {op, sa, sb, s, ec};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(logic rdy, logic z, logic [31:0] ins, logic [17:0] e);
    step_t s;
    s.rdy = rdy; s.z = z; s.ins = ins; s.e = e;
    plan.push_back(s);
  endfunction

  // Reference model: expected cycle-by-cycle outputs of one instruction.
  function automatic void plan_instr(logic [31:0] ins, int fw, int mw, logic z);
    logic [10:0] op;
    logic [3:0]  a;
    op = ins[31:21];
    for (int i = 0; i < fw; i++) push(1'b0, rb(), $urandom, ev(OP_ADD, 1'b0, 2'b01, MR, 2'b00));
    push(1'b1, rb(), ins, ev(OP_ADD, 1'b0, 2'b01, MR | IRW | PCW, 2'b00));
    push(rb(), rb(), $urandom, '0);
    if (op == C_ADD || op == C_SUB || op == C_AND || op == C_ORR) begin
      a = (op == C_ADD) ? OP_ADD : (op == C_SUB) ? OP_SUB : (op == C_AND) ? OP_AND : OP_ORR;
      push(rb(), rb(), $urandom, ev(a, 1'b1, 2'b00, 9'h000, 2'b00));
      push(rb(), rb(), $urandom, ev(a, 1'b1, 2'b00, RW, 2'b00));
      retired_model++;
    end else if (op == C_LDUR || op == C_STUR) begin
      push(rb(), rb(), $urandom, ev(OP_ADD, 1'b1, 2'b10, 9'h000, 2'b00));
      for (int i = 0; i <= mw; i++)
        push(i == mw, rb(), $urandom,
             ev(OP_ADD, 1'b1, 2'b10, (op == C_LDUR) ? MR : (MW | R2L), 2'b00));
      if (op == C_LDUR) push(rb(), rb(), $urandom, ev(4'b0000, 1'b0, 2'b00, RW | M2R, 2'b00));
      retired_model++;
    end else if (ins[31:24] == 8'hB4) begin
      push(rb(), z, $urandom, ev(OP_PASS, 1'b0, 2'b00, R2L | (z ? (PCW | PCS) : 9'h000), 2'b00));
      retired_model++;
    end else if (ins[31:26] == 6'b000101) begin
      push(rb(), rb(), $urandom, ev(4'b0000, 1'b0, 2'b00, PCW | PCS, 2'b00));
      retired_model++;
    end else begin
      for (int i = 0; i < 20; i++) push(rb(), rb(), $urandom, ev(4'b0000, 1'b0, 2'b00, ILL, 2'b01));
    end
  endfunction

  function automatic logic [31:0] rand_instr(int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0: return {C_ADD, r[20:0]};
      1: return {C_SUB, r[20:0]};
      2: return {C_AND, r[20:0]};
      3: return {C_ORR, r[20:0]};
      4: return {C_LDUR, r[20:0]};
      5: return {C_STUR, r[20:0]};
      6: return {8'hB4, r[23:0]};
      default: return {6'b000101, r[25:0]};
    endcase
  endfunction

  task automatic step(input logic r, input logic rdy, input logic z, input logic [31:0] ins,
                      output logic [17:0] obs);
    @(negedge clk);
    rst = r; mem_ready = rdy; zero = z; instr = ins;
    #1;
    obs = {alu_op, alu_src_a, alu_src_b, mem_read, mem_write, ir_write, pc_write,
           reg_write, pc_src, reg2_loc, mem_to_reg, illegal, err_code};
  endtask

  task automatic do_reset();
    logic [17:0] o;
    step(1'b1, rb(), rb(), $urandom, o);
    step(1'b1, rb(), rb(), $urandom, o);
    retired_model = 0;
    plan.delete();
  endtask

  task automatic test_reset();
    logic [17:0] o;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, rb(), rb(), $urandom, o);
      n_cmp++;
      if (o !== 18'd0) begin n_bad++; $display("FAIL reset_quiet cyc %0d: got %h want %h", i, o, 18'd0); end
    end
`ifdef CTRL_PERF_CNT_EN
    n_cmp++;
    if (retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
`endif
    step(1'b0, 1'b0, rb(), $urandom, o);
    n_cmp++;
    if (o !== ev(OP_ADD, 1'b0, 2'b01, MR, 2'b00)) begin
      n_bad++; $display("FAIL reset_fetch: got %h want %h", o, ev(OP_ADD, 1'b0, 2'b01, MR, 2'b00));
    end
  endtask

  task automatic test_rtype();
    logic [17:0] o;
    int unsigned er;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      er = retired_model;
      if (n == 0) plan_instr(32'h8B030041, 0, 0, 1'b0);
      else plan_instr(rand_instr($urandom_range(0, 3)), $urandom_range(0, MAXW), 0, 1'b0);
      foreach (plan[k]) begin
        step(1'b0, plan[k].rdy, plan[k].z, plan[k].ins, o);
        n_cmp++;
        if (o !== plan[k].e) begin n_bad++; $display("FAIL rtype i%0d s%0d: got %h want %h", n, k, o, plan[k].e); end
`ifdef CTRL_PERF_CNT_EN
        if (k == 0) begin
          n_cmp++;
          if (retired !== er) begin n_bad++; $display("FAIL rtype_retired i%0d: got %0d want %0d", n, retired, er); end
        end
`endif
      end
      plan.delete();
    end
  endtask

  task automatic test_mem();
    logic [17:0] o;
    int unsigned er;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      er = retired_model;
      if (n == 0)      plan_instr(32'hF8408041, 0, 3, 1'b0);
      else if (n == 1) plan_instr(rand_instr(4), MAXW, MAXW, 1'b0);
      else if (n == 2) plan_instr(rand_instr(5), 0, MAXW, 1'b0);
      else plan_instr(rand_instr($urandom_range(4, 5)), $urandom_range(0, MAXW),
                      $urandom_range(0, MAXW), 1'b0);
      foreach (plan[k]) begin
        step(1'b0, plan[k].rdy, plan[k].z, plan[k].ins, o);
        n_cmp++;
        if (o !== plan[k].e) begin n_bad++; $display("FAIL mem i%0d s%0d: got %h want %h", n, k, o, plan[k].e); end
`ifdef CTRL_PERF_CNT_EN
        if (k == 0) begin
          n_cmp++;
          if (retired !== er) begin n_bad++; $display("FAIL mem_retired i%0d: got %0d want %0d", n, retired, er); end
        end
`endif
      end
      plan.delete();
    end
  endtask

  task automatic test_branch();
    logic [17:0] o;
    int unsigned er;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      er = retired_model;
      if (n < 2) plan_instr(32'hB4000045, 0, 0, (n == 0));
      else plan_instr(rand_instr($urandom_range(6, 7)), $urandom_range(0, MAXW), 0, rb());
      foreach (plan[k]) begin
        step(1'b0, plan[k].rdy, plan[k].z, plan[k].ins, o);
        n_cmp++;
        if (o !== plan[k].e) begin n_bad++; $display("FAIL branch i%0d s%0d: got %h want %h", n, k, o, plan[k].e); end
`ifdef CTRL_PERF_CNT_EN
        if (k == 0) begin
          n_cmp++;
          if (retired !== er) begin n_bad++; $display("FAIL branch_retired i%0d: got %0d want %0d", n, retired, er); end
        end
`endif
      end
      plan.delete();
    end
  endtask

  task automatic test_illegal();
    logic [17:0] o;
    logic [31:0] bad [6];
    bad = '{32'h00000000, 32'hFFFFFFFF, 32'h8B200000, 32'hF8600000, 32'hB5000000, 32'h1C000000};
    for (int n = 0; n < 6; n++) begin
      do_reset();
      plan_instr(bad[n], $urandom_range(0, MAXW), 0, 1'b0);
      foreach (plan[k]) begin
        step(1'b0, plan[k].rdy, plan[k].z, plan[k].ins, o);
        n_cmp++;
        if (o !== plan[k].e) begin n_bad++; $display("FAIL illegal %h s%0d: got %h want %h", bad[n], k, o, plan[k].e); end
      end
      plan.delete();
    end
  endtask

  task automatic test_timeout();
    logic [17:0] o;
    for (int n = 0; n < 3; n++) begin
      do_reset();
      if (n == 0) begin
        plan_instr(rand_instr(0), 0, 0, 1'b0);
        for (int i = 0; i < MAXW; i++) push(1'b0, rb(), $urandom, ev(OP_ADD, 1'b0, 2'b01, MR, 2'b00));
        push(1'b0, rb(), $urandom, ev(OP_ADD, 1'b0, 2'b01, 9'h000, 2'b00));
      end else begin
        push(1'b1, rb(), rand_instr(n + 3), ev(OP_ADD, 1'b0, 2'b01, MR | IRW | PCW, 2'b00));
        push(rb(), rb(), $urandom, '0);
        push(rb(), rb(), $urandom, ev(OP_ADD, 1'b1, 2'b10, 9'h000, 2'b00));
        for (int i = 0; i < MAXW; i++)
          push(1'b0, rb(), $urandom, ev(OP_ADD, 1'b1, 2'b10, (n == 1) ? MR : (MW | R2L), 2'b00));
        push(1'b0, rb(), $urandom, ev(OP_ADD, 1'b1, 2'b10, (n == 1) ? 9'h000 : R2L, 2'b00));
      end
      for (int i = 0; i < 6; i++) push(rb(), rb(), $urandom, ev(4'b0000, 1'b0, 2'b00, ILL, 2'b10));
      foreach (plan[k]) begin
        step(1'b0, plan[k].rdy, plan[k].z, plan[k].ins, o);
        n_cmp++;
        if (o !== plan[k].e) begin n_bad++; $display("FAIL timeout c%0d s%0d: got %h want %h", n, k, o, plan[k].e); end
`ifdef CTRL_PERF_CNT_EN
        if (k == plan.size() - 1) begin
          n_cmp++;
          if (retired !== retired_model) begin
            n_bad++; $display("FAIL timeout_retired c%0d: got %0d want %0d", n, retired, retired_model);
          end
        end
`endif
      end
      plan.delete();
    end
  endtask

  task automatic test_rst_abort();
    logic [17:0] o;
    for (int n = 0; n < 2; n++) begin
      do_reset();
      plan_instr(rand_instr(n == 0 ? 4 : 1), 0, 2, 1'b0);
      // Abort LDUR inside MEM_RD, or R-type on its write-back cycle.
      for (int k = 0; k < (n == 0 ? 4 : 3); k++) begin
        step(1'b0, plan[k].rdy, plan[k].z, plan[k].ins, o);
        n_cmp++;
        if (o !== plan[k].e) begin n_bad++; $display("FAIL abort c%0d s%0d: got %h want %h", n, k, o, plan[k].e); end
      end
      step(1'b1, 1'b1, 1'b1, $urandom, o);
      n_cmp++;
      if (o !== 18'd0) begin n_bad++; $display("FAIL abort_quiet c%0d: got %h want %h", n, o, 18'd0); end
      step(1'b0, 1'b0, rb(), $urandom, o);
      n_cmp++;
      if (o !== ev(OP_ADD, 1'b0, 2'b01, MR, 2'b00)) begin
        n_bad++; $display("FAIL abort_refetch c%0d: got %h want %h", n, o, ev(OP_ADD, 1'b0, 2'b01, MR, 2'b00));
      end
`ifdef CTRL_PERF_CNT_EN
      n_cmp++;
      if (retired !== 32'd0) begin n_bad++; $display("FAIL abort_retired c%0d: got %0d want 0", n, retired); end
`endif
      plan.delete();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_illegal();
    test_timeout();
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
